mem1port_arb: RTL and testbench

- Arbiter and bridge directly upstream of the single-port memory model, `mem1port`.
- Merges the core's instruction read port and data read/write ports onto one shared port: single-cycle request, write enable, read response one cycle later.
- Selects one access per cycle and returns per-requester grants, so the core stalls locally.
- Routes the delayed read response back to whichever port issued the read.

---
 rtl/mem1port_arb_pkg.sv | 40 ++++
 rtl/mem1port_arb_if.sv | 47 ++++
 rtl/mem1port_arb_wbuf.sv | 64 ++++++
 rtl/mem1port_arb.sv | 142 ++++++++++++++
 tb/tb_mem1port_arb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem1port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the mem1port arbiter: response
//               owner encoding, access source select, starvation bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Port that issued the outstanding read; INSTR is the reset owner
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Which request drives the shared memory port this cycle
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_IRD  = 3'd1,
        SRC_DRD  = 3'd2,
        SRC_DWR  = 3'd3,
        SRC_WBUF = 3'd4
    } src_e;

    localparam int c_starve_max_lo = 1;
    localparam int c_starve_max_hi = 15;
    localparam int c_starve_cnt_w  = 4;

    // Keep the starvation limit inside the range the 4-bit counter can hold
    function automatic int starve_clamp(input int value);
        if (value < c_starve_max_lo) begin
            return c_starve_max_lo;
        end else if (value > c_starve_max_hi) begin
            return c_starve_max_hi;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem1port_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem1port_arb_if
// Description : Bundle of the core-side request/response ports and the
//               memory-side shared port around the mem1port arbiter.
//               slave = arbiter view, master = core + memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem1port_arb_if;
    logic        i_rready;
    logic [29:0] i_raddr;
    logic        i_gnt;
    logic        i_rresp;
    logic [31:0] i_rdata;
    logic        d_rready;
    logic [29:0] d_raddr;
    logic        d_rgnt;
    logic        d_rresp;
    logic [31:0] d_rdata;
    logic        d_wready;
    logic [29:0] d_waddr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_wgnt;
    logic        m_ready;
    logic        m_we;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rresp;
    logic [31:0] m_rdata;

    modport slave (
        input  i_rready, i_raddr, d_rready, d_raddr, d_wready, d_waddr,
               d_wdata, d_wstrb, m_rresp, m_rdata,
        output i_gnt, i_rresp, i_rdata, d_rgnt, d_rresp, d_rdata, d_wgnt,
               m_ready, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output i_rready, i_raddr, d_rready, d_raddr, d_wready, d_waddr,
               d_wdata, d_wstrb, m_rresp, m_rdata,
        input  i_gnt, i_rresp, i_rdata, d_rgnt, d_rresp, d_rdata, d_wgnt,
               m_ready, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/mem1port_arb_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf
// Description : One-entry posted write buffer. Accepts a write when empty or
//               draining, and raises an urgent drain request when a new write
//               arrives or a pending read targets the buffered word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wbuf #(
    parameter int ADDRW = 30
) (
    input  wire logic        clk,
    input  wire logic        resetb,
    input  wire logic        wr_req,
    input  wire logic [29:0] wr_addr,
    input  wire logic [31:0] wr_data,
    input  wire logic [3:0]  wr_strb,
    input  wire logic        drain,
    input  wire logic        rd_i_req,
    input  wire logic [29:0] rd_i_addr,
    input  wire logic        rd_d_req,
    input  wire logic [29:0] rd_d_addr,
    output logic             valid,
    output logic             urgent,
    output logic             wr_gnt,
    output logic [29:0]      buf_addr,
    output logic [31:0]      buf_data,
    output logic [3:0]       buf_strb
);
    logic             r_valid;
    logic [ADDRW-1:0] r_addr;
    logic [31:0]      r_data;
    logic [3:0]       r_strb;
    logic             w_hit_i;
    logic             w_hit_d;

    // A read of the buffered word must wait for the drain: there is no forwarding
    assign w_hit_i  = rd_i_req && (rd_i_addr[ADDRW-1:0] == r_addr);
    assign w_hit_d  = rd_d_req && (rd_d_addr[ADDRW-1:0] == r_addr);
    assign urgent   = r_valid && (wr_req || w_hit_i || w_hit_d);
    assign wr_gnt   = wr_req && (!r_valid || drain);
    assign valid    = r_valid;
    assign buf_addr = 30'(r_addr);
    assign buf_data = r_data;
    assign buf_strb = r_strb;

    // Capture on accept (may overlap a drain), otherwise empty on drain
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_strb  <= '0;
        end else if (wr_gnt) begin
            r_valid <= 1'b1;
            r_addr  <= wr_addr[ADDRW-1:0];
            r_data  <= wr_data;
            r_strb  <= wr_strb;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem1port_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem1port_arb
// Description : Merges instruction read and data read/write ports onto the
//               single mem1port port, with starvation protection for the
//               instruction port and owner-based read response routing.
//               Optional posted write buffer: MEM1PORT_ARB_WBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem1port_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int WBUF_ADDRW = 30
) (
    input  wire logic       clk,
    input  wire logic       resetb,
    mem1port_arb_if.slave   bus
);
    localparam logic [c_starve_cnt_w-1:0] c_starve_max =
        c_starve_cnt_w'(starve_clamp(STARVE_MAX));

    logic [c_starve_cnt_w-1:0] r_starve_cnt;
    owner_e                    r_owner;
    src_e                      w_src;
    logic                      w_force_i;

`ifdef MEM1PORT_ARB_WBUF_EN
    logic        w_wb_valid;
    logic        w_wb_urgent;
    logic        w_wb_wr_gnt;
    logic [29:0] w_wb_addr;
    logic [31:0] w_wb_data;
    logic [3:0]  w_wb_strb;

    mem_wbuf #(
        .ADDRW     (WBUF_ADDRW)
    ) u_wbuf (
        .clk       (clk),
        .resetb    (resetb),
        .wr_req    (bus.d_wready && resetb),
        .wr_addr   (bus.d_waddr),
        .wr_data   (bus.d_wdata),
        .wr_strb   (bus.d_wstrb),
        .drain     (w_src == SRC_WBUF),
        .rd_i_req  (bus.i_rready),
        .rd_i_addr (bus.i_raddr),
        .rd_d_req  (bus.d_rready),
        .rd_d_addr (bus.d_raddr),
        .valid     (w_wb_valid),
        .urgent    (w_wb_urgent),
        .wr_gnt    (w_wb_wr_gnt),
        .buf_addr  (w_wb_addr),
        .buf_data  (w_wb_data),
        .buf_strb  (w_wb_strb)
    );
`endif

    assign w_force_i = bus.i_rready && (r_starve_cnt == c_starve_max);

    // Pick the single winner for the shared port; nothing wins during reset
    always_comb begin
        w_src = SRC_NONE;
        if (resetb) begin
`ifdef MEM1PORT_ARB_WBUF_EN
            if (w_wb_urgent)        w_src = SRC_WBUF;
            else if (w_force_i)     w_src = SRC_IRD;
            else if (bus.d_rready)  w_src = SRC_DRD;
            else if (bus.i_rready)  w_src = SRC_IRD;
            else if (w_wb_valid)    w_src = SRC_WBUF;
`else
            if (w_force_i)          w_src = SRC_IRD;
            else if (bus.d_wready)  w_src = SRC_DWR;
            else if (bus.d_rready)  w_src = SRC_DRD;
            else if (bus.i_rready)  w_src = SRC_IRD;
`endif
        end
    end

    assign bus.i_gnt   = (w_src == SRC_IRD);
    assign bus.d_rgnt  = (w_src == SRC_DRD);
`ifdef MEM1PORT_ARB_WBUF_EN
    assign bus.d_wgnt  = w_wb_wr_gnt;
`else
    assign bus.d_wgnt  = (w_src == SRC_DWR);
`endif
    assign bus.m_ready = (w_src != SRC_NONE);
    assign bus.m_we    = (w_src == SRC_DWR) || (w_src == SRC_WBUF);

    // Steer address and write payload from the winning source
    always_comb begin
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        case (w_src)
            SRC_IRD: bus.m_addr = bus.i_raddr;
            SRC_DRD: bus.m_addr = bus.d_raddr;
            SRC_DWR: begin
                bus.m_addr  = bus.d_waddr;
                bus.m_wdata = bus.d_wdata;
                bus.m_wstrb = bus.d_wstrb;
            end
`ifdef MEM1PORT_ARB_WBUF_EN
            SRC_WBUF: begin
                bus.m_addr  = w_wb_addr;
                bus.m_wdata = w_wb_data;
                bus.m_wstrb = w_wb_strb;
            end
`endif
            default: ;
        endcase
    end

    // Count consecutive denied instruction cycles, saturating at the limit
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_starve_cnt <= '0;
        end else if (!bus.i_rready || (w_src == SRC_IRD)) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Remember which port issued the read so its response goes back there
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_owner <= OWNER_INSTR;
        end else if (w_src == SRC_IRD) begin
            r_owner <= OWNER_INSTR;
        end else if (w_src == SRC_DRD) begin
            r_owner <= OWNER_DATA;
        end
    end

    assign bus.i_rresp = bus.m_rresp && (r_owner == OWNER_INSTR);
    assign bus.d_rresp = bus.m_rresp && (r_owner == OWNER_DATA);
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem1port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem1port_arb
// Description : Directed table-driven bench for mem1port_arb with a small
//               behavioural mem1port model (1-cycle read, byte strobes).
//               The buffered-write sequence runs when MEM1PORT_ARB_WBUF_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem1port_arb;
    logic clk    = 1'b0;
    logic resetb = 1'b0;
    logic inject = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem1port_arb_if bus ();

    mem1port_arb #(
        .STARVE_MAX (4),
        .WBUF_ADDRW (30)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    // Memory model: read data one cycle after a read strobe, cleared by reset
    logic [31:0] mem [0:255];
    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bus.m_rresp <= 1'b0;
            bus.m_rdata <= '0;
        end else begin
            bus.m_rresp <= (bus.m_ready && !bus.m_we) || inject;
            bus.m_rdata <= mem[bus.m_addr[7:0]];
            if (bus.m_ready && bus.m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.m_wstrb[b]) mem[bus.m_addr[7:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        ir;
        logic [29:0] ia;
        logic        dr;
        logic [29:0] da;
        logic        dw;
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [4:0]  ctl;   // {i_gnt, d_rgnt, d_wgnt, m_ready, m_we}
        logic [29:0] addr;
        logic [1:0]  resp;  // {i_rresp, d_rresp}
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [29:0] ia,
                                input logic dr, input logic [29:0] da,
                                input logic dw, input logic [29:0] wa,
                                input logic [31:0] wd, input logic [3:0] ws,
                                input logic [4:0] ctl, input logic [29:0] addr,
                                input logic [1:0] resp, input logic [31:0] rdata);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.wa = wa;
        v.wd = wd; v.ws = ws; v.ctl = ctl; v.addr = addr; v.resp = resp;
        v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic [29:0] ia,
                         input logic dr, input logic [29:0] da,
                         input logic dw, input logic [29:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws);
        bus.i_rready = ir; bus.i_raddr = ia;
        bus.d_rready = dr; bus.d_raddr = da;
        bus.d_wready = dw; bus.d_waddr = wa;
        bus.d_wdata  = wd; bus.d_wstrb = ws;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {bus.i_gnt, bus.d_rgnt, bus.d_wgnt, bus.m_ready, bus.m_we};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {27'd0, ctl_now()}, 32'd0);
        chk("reset_resp", {30'd0, bus.i_rresp, bus.d_rresp}, 32'd0);
        @(posedge clk);
        #1 resetb = 1'b1;

        //             ir  ia     dr  da     dw  wa     wd            ws       ctl       addr   resp   rdata
        vecs.push_back(mk(0, 0,     0, 0,     0, 0,     0,            0,       5'b00000, 0,     2'b00, 0));
        vecs.push_back(mk(1, 'h10,  0, 0,     0, 0,     0,            0,       5'b10010, 'h10,  2'b00, 0));
        vecs.push_back(mk(0, 0,     0, 0,     0, 0,     0,            0,       5'b00000, 0,     2'b10, 32'hA000_0010));
        vecs.push_back(mk(1, 'h30,  1, 'h20,  0, 0,     0,            0,       5'b01010, 'h20,  2'b00, 0));
        vecs.push_back(mk(1, 'h30,  0, 0,     0, 0,     0,            0,       5'b10010, 'h30,  2'b01, 32'hA000_0020));
        vecs.push_back(mk(0, 0,     0, 0,     0, 0,     0,            0,       5'b00000, 0,     2'b10, 32'hA000_0030));
`ifndef MEM1PORT_ARB_WBUF_EN
        vecs.push_back(mk(0, 0,     1, 'h40,  1, 'h40,  32'hDEADBEEF, 4'hF,    5'b00111, 'h40,  2'b00, 0));
        vecs.push_back(mk(0, 0,     1, 'h40,  0, 0,     0,            0,       5'b01010, 'h40,  2'b00, 0));
        vecs.push_back(mk(0, 0,     0, 0,     0, 0,     0,            0,       5'b00000, 0,     2'b01, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0,     0, 0,     1, 'h41,  32'h11223344, 4'b0101, 5'b00111, 'h41,  2'b00, 0));
        vecs.push_back(mk(0, 0,     1, 'h41,  0, 0,     0,            0,       5'b01010, 'h41,  2'b00, 0));
        vecs.push_back(mk(0, 0,     0, 0,     0, 0,     0,            0,       5'b00000, 0,     2'b01, 32'hA022_0044));
`endif

        foreach (vecs[k]) begin
            drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].da,
                  vecs[k].dw, vecs[k].wa, vecs[k].wd, vecs[k].ws);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", k), {27'd0, ctl_now()}, {27'd0, vecs[k].ctl});
            if (vecs[k].ctl[1]) chk($sformatf("vec%0d_addr", k), {2'b0, bus.m_addr}, {2'b0, vecs[k].addr});
            chk($sformatf("vec%0d_resp", k), {30'd0, bus.i_rresp, bus.d_rresp}, {30'd0, vecs[k].resp});
            if (vecs[k].resp[1]) chk($sformatf("vec%0d_irdata", k), bus.i_rdata, vecs[k].rdata);
            if (vecs[k].resp[0]) chk($sformatf("vec%0d_drdata", k), bus.d_rdata, vecs[k].rdata);
            next_cycle();
        end

        // Starvation: data reads win 4 times, then the instruction read is forced
        idle();
        next_cycle();
        drive(1'b1, 30'h60, 1'b1, 30'h61, 1'b0, '0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("starve_deny%0d", c), {30'd0, bus.i_gnt, bus.d_rgnt}, 32'b01);
            next_cycle();
        end
        @(negedge clk);
        chk("starve_force", {30'd0, bus.i_gnt, bus.d_rgnt}, 32'b10);
        chk("starve_force_addr", {2'b0, bus.m_addr}, 32'h60);
        next_cycle();
        @(negedge clk);
        chk("starve_cleared", {30'd0, bus.i_gnt, bus.d_rgnt}, 32'b01);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();

        // Reset right after a data read grant drops the pending response
        drive(1'b0, '0, 1'b1, 30'h20, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("pre_reset_dgnt", {31'd0, bus.d_rgnt}, 32'd1);
        next_cycle();
        chk("pre_reset_dresp", {31'd0, bus.d_rresp}, 32'd1);
        bus.i_rready = 1'b1;
        bus.i_raddr  = 30'h10;
        resetb = 1'b0;
        #1;
        chk("in_reset_ctl", {27'd0, ctl_now()}, 32'd0);
        chk("in_reset_dresp", {31'd0, bus.d_rresp}, 32'd0);
        next_cycle();
        idle();
        resetb = 1'b1;
        next_cycle();
        // A bare memory response now must route to the reset owner (INSTR)
        inject = 1'b1;
        next_cycle();
        inject = 1'b0;
        @(negedge clk);
        chk("post_reset_owner", {30'd0, bus.i_rresp, bus.d_rresp}, 32'b10);
        next_cycle();

`ifdef MEM1PORT_ARB_WBUF_EN
        // Posted write then read of the same word: drain before the read
        drive(1'b0, '0, 1'b0, '0, 1'b1, 30'h50, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("wb_accept", {27'd0, ctl_now()}, 32'b00100);
        next_cycle();
        drive(1'b0, '0, 1'b1, 30'h50, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("wb_drain", {27'd0, ctl_now()}, 32'b00011);
        chk("wb_drain_addr", {2'b0, bus.m_addr}, 32'h50);
        next_cycle();
        @(negedge clk);
        chk("wb_read", {27'd0, ctl_now()}, 32'b01010);
        next_cycle();
        idle();
        @(negedge clk);
        chk("wb_rdata", bus.d_rdata, 32'h12345678);
        chk("wb_dresp", {31'd0, bus.d_rresp}, 32'd1);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
